// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shared barrier lane arbiter that owns the occupancy count.
// Define PARK_EXIT_PRIORITY_EN to make exit win every tie instead of round-robin.
module parking_gate_arbiter #(
    parameter int CAPACITY     = 999,
    parameter int CNT_W        = 10,
    parameter int OPEN_CYCLES  = 12_000_000,
    parameter int GUARD_CYCLES = 1_200_000,
    parameter int TMR_W        = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_in,
    input  logic             car_out,
    output logic             gate_open,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, GNT_IN, GNT_OUT, GUARD} state_t;

    state_t            r_state;
    state_t            w_next;
    state_t            w_arb;
    logic [TMR_W-1:0]  r_tmr;
    logic              w_ent_ok;
    logic              w_ext_ok;
    logic              w_tie;
    logic              w_pick_exit;
    logic              w_granted;
    logic              w_pass;
    logic              w_open_end;
    logic              w_guard_end;
    logic              w_decide;
    logic [CNT_W-1:0]  w_occ;
    logic              w_gate;
    logic              w_ge;
    logic              w_gx;
    logic              w_to;
`ifndef PARK_EXIT_PRIORITY_EN
    logic              r_last_exit;
`endif

    // Arbitration happens in IDLE and on the last GUARD cycle, so a held
    // request is granted immediately after the guard window closes.
    always_comb begin
        w_ent_ok    = entry_req && !full;
        w_ext_ok    = exit_req && !empty;
        w_tie       = w_ent_ok && w_ext_ok;
`ifdef PARK_EXIT_PRIORITY_EN
        w_pick_exit = w_ext_ok;
`else
        w_pick_exit = w_tie ? !r_last_exit : w_ext_ok;
`endif
        w_arb       = w_pick_exit ? GNT_OUT : (w_ent_ok ? GNT_IN : IDLE);
        w_granted   = r_state == GNT_IN || r_state == GNT_OUT;
        w_pass      = (r_state == GNT_IN && car_in) || (r_state == GNT_OUT && car_out);
        w_open_end  = r_tmr == TMR_W'(OPEN_CYCLES - 1);
        w_guard_end = r_tmr == TMR_W'(GUARD_CYCLES - 1);
        w_decide    = r_state == IDLE || (r_state == GUARD && w_guard_end);
    end

    always_comb begin
        w_next = r_state;
        if (w_decide)
            w_next = w_arb;
        else if (w_granted && (w_pass || w_open_end))
            w_next = GUARD;
    end

    always_comb begin
        w_occ = occupancy;
        if (r_state == GNT_IN && car_in && occupancy < CNT_W'(CAPACITY))
            w_occ = occupancy + CNT_W'(1);
        else if (r_state == GNT_OUT && car_out && occupancy != '0)
            w_occ = occupancy - CNT_W'(1);
        w_gate = w_next == GNT_IN || w_next == GNT_OUT;
        w_ge   = w_next == GNT_IN;
        w_gx   = w_next == GNT_OUT;
        w_to   = w_granted && w_open_end && !w_pass;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tmr       <= '0;
            occupancy   <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            gate_open   <= 1'b0;
            grant_entry <= 1'b0;
            grant_exit  <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_tmr       <= (w_next != r_state) ? '0 : r_tmr + TMR_W'(1);
            occupancy   <= w_occ;
            full        <= w_occ == CNT_W'(CAPACITY);
            empty       <= w_occ == '0;
            gate_open   <= w_gate;
            grant_entry <= w_ge;
            grant_exit  <= w_gx;
            timeout     <= w_to;
        end
    end

`ifndef PARK_EXIT_PRIORITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_last_exit <= 1'b1;
        else if (w_decide && w_tie)
            r_last_exit <= w_pick_exit;
    end
`endif
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed scenarios with a cycle-stamped expected-output scoreboard.
module tb_parking_gate_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       car_in = 1'b0;
    logic       car_out = 1'b0;
    logic       gate_open;
    logic       grant_entry;
    logic       grant_exit;
    logic [3:0] occupancy;
    logic       full;
    logic       empty;
    logic       timeout;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int         exp_cyc[$];
    logic [9:0] exp_val[$];
    string      exp_name[$];
    logic [9:0] prev = 'x;

    parking_gate_arbiter #(
        .CAPACITY(3), .CNT_W(4), .OPEN_CYCLES(8), .GUARD_CYCLES(4), .TMR_W(4)
    ) dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
        .car_in(car_in), .car_out(car_out), .gate_open(gate_open),
        .grant_entry(grant_entry), .grant_exit(grant_exit), .occupancy(occupancy),
        .full(full), .empty(empty), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tuple layout: gate, grant_entry, grant_exit, timeout, full, empty, occupancy
    function automatic logic [9:0] mk(input logic g, ge, gx, to, f, e, input logic [3:0] o);
        return {g, ge, gx, to, f, e, o};
    endfunction

    task automatic expect_at(input int off, input logic [9:0] v, input string name);
        exp_cyc.push_back(cyc + off);
        exp_val.push_back(v);
        exp_name.push_back(name);
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every change of the output tuple must match the next expected entry, value and cycle.
    always @(negedge clk) begin
        logic [9:0] w;
        w = {gate_open, grant_entry, grant_exit, timeout, full, empty, occupancy};
        if (w !== prev) begin
            n_vec++;
            if (exp_val.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected: outputs %b at cycle %0d, no change expected", w, cyc);
            end else begin
                int         c;
                logic [9:0] v;
                string      s;
                c = exp_cyc.pop_front();
                v = exp_val.pop_front();
                s = exp_name.pop_front();
                if (w !== v || cyc != c) begin
                    n_bad++;
                    $display("FAIL %s: got %b at cycle %0d, want %b at cycle %0d", s, w, cyc, v, c);
                end
            end
        end
        prev = w;
    end

    initial begin
        expect_at(1, mk(0,0,0,0,0,1,4'd0), "reset");
        go(2);
        rst = 1'b0; entry_req = 1'b1;
        expect_at(1, mk(1,1,0,0,0,1,4'd0), "first_grant");
        go(3);
        car_in = 1'b1;
        expect_at(1, mk(0,0,0,0,0,0,4'd1), "entry_pass");
        go(1);
        car_in = 1'b0; exit_req = 1'b1;
        expect_at(4, mk(1,1,0,0,0,0,4'd1), "rr_tie1_entry");
        go(4);
        car_in = 1'b1;
        expect_at(1, mk(0,0,0,0,0,0,4'd2), "rr_pass1");
        go(1);
        car_in = 1'b0;
        expect_at(4, mk(1,0,1,0,0,0,4'd2), "rr_tie2_exit");
        go(4);
        car_out = 1'b1;
        expect_at(1, mk(0,0,0,0,0,0,4'd1), "rr_pass2");
        go(1);
        car_out = 1'b0;
        expect_at(4, mk(1,1,0,0,0,0,4'd1), "rr_tie3_entry");
        go(4);
        car_in = 1'b1;
        expect_at(1, mk(0,0,0,0,0,0,4'd2), "rr_pass3");
        go(1);
        car_in = 1'b0;
        expect_at(4, mk(1,0,1,0,0,0,4'd2), "rr_tie4_exit");
        go(4);
        car_out = 1'b1;
        expect_at(1, mk(0,0,0,0,0,0,4'd1), "rr_pass4");
        go(1);
        car_out = 1'b0; exit_req = 1'b0;
        expect_at(4, mk(1,1,0,0,0,0,4'd1), "to_grant");
        go(4);
        expect_at(8, mk(0,0,0,1,0,0,4'd1), "timeout_pulse");
        expect_at(9, mk(0,0,0,0,0,0,4'd1), "timeout_end");
        expect_at(12, mk(1,1,0,0,0,0,4'd1), "regrant_after_guard");
        go(12);
        entry_req = 1'b0;
        expect_at(8, mk(0,0,0,0,0,0,4'd2), "race_pass_wins");
        go(2);
        car_out = 1'b1;
        go(1);
        car_out = 1'b0;
        go(4);
        car_in = 1'b1;
        go(1);
        car_in = 1'b0;
        go(1);
        car_in = 1'b1;
        go(1);
        car_in = 1'b0;
        go(4);
        car_out = 1'b1;
        go(1);
        car_out = 1'b0; entry_req = 1'b1;
        expect_at(1, mk(1,1,0,0,0,0,4'd2), "fill_grant");
        go(1);
        car_in = 1'b1;
        expect_at(1, mk(0,0,0,0,1,0,4'd3), "full_reached");
        go(1);
        car_in = 1'b0;
        go(8);
        exit_req = 1'b1;
        expect_at(1, mk(1,0,1,0,1,0,4'd3), "exit_when_full");
        go(1);
        car_out = 1'b1;
        expect_at(1, mk(0,0,0,0,0,0,4'd2), "exit_pass1");
        go(1);
        car_out = 1'b0; entry_req = 1'b0;
        expect_at(4, mk(1,0,1,0,0,0,4'd2), "exit_grant2");
        go(4);
        car_out = 1'b1;
        expect_at(1, mk(0,0,0,0,0,0,4'd1), "exit_pass2");
        go(1);
        car_out = 1'b0;
        expect_at(4, mk(1,0,1,0,0,0,4'd1), "exit_grant3");
        go(4);
        car_out = 1'b1;
        expect_at(1, mk(0,0,0,0,0,1,4'd0), "empty_reached");
        go(1);
        car_out = 1'b0;
        go(10);
        entry_req = 1'b1;
        expect_at(1, mk(1,1,0,0,0,1,4'd0), "refill_grant");
        go(1);
        car_in = 1'b1;
        expect_at(1, mk(0,0,0,0,0,0,4'd1), "refill_pass");
        go(1);
        car_in = 1'b0; entry_req = 1'b0;
        expect_at(4, mk(1,0,1,0,0,0,4'd1), "exit_before_reset");
        go(4);
        go(2);
        rst = 1'b1; car_out = 1'b1;
        expect_at(1, mk(0,0,0,0,0,1,4'd0), "reset_mid_grant");
        go(1);
        rst = 1'b0; car_out = 1'b0; exit_req = 1'b0;
        go(5);
        while (exp_val.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: never observed, want %b at cycle %0d",
                     exp_name.pop_front(), exp_val.pop_front(), exp_cyc.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
